// File: rtl/rbe_package.sv
// Shared types and constants for the RBE scaling datapath.
package rbe_package;

    localparam int RBE_SCALE_SATCNT_W = 16;
    localparam int RBE_SCALE_N_SHIFTS = 8;
    localparam int RBE_SCALE_SEL_W    = $clog2(RBE_SCALE_N_SHIFTS);

    typedef struct packed {
        logic [RBE_SCALE_SEL_W-1:0] shift_sel;
        logic                       right_shift;
        logic                       signed_mode;
        logic                       round_en;
        logic                       saturate;
        logic                       clear;
    } ctrl_scale_pipe_t;

    typedef struct packed {
        logic                          busy;
        logic [RBE_SCALE_SATCNT_W-1:0] sat_count;
        logic [RBE_SCALE_SEL_W-1:0]    shift_sel;
    } flags_scale_pipe_t;

endpackage

// File: rtl/rbe_scale_pipe_ch.sv
// Single-channel combinational scaler: an extend/round/shift path feeding stage 1
// and an independent clamp/truncate path fed from the stage-1 register.
module rbe_scale_pipe_ch
    import rbe_package::*;
#(
    parameter int  INP_ACC  = 8,
    parameter int  OUT_ACC  = 16,
    parameter int  N_SHIFTS = RBE_SCALE_N_SHIFTS,
    localparam int W        = INP_ACC + N_SHIFTS + 1
) (
    input  logic [INP_ACC-1:0]         x,
    input  logic [RBE_SCALE_SEL_W-1:0] sel,
    input  logic                       right_shift,
    input  logic                       signed_mode,
    input  logic                       round_en,
    output logic [W-1:0]               shifted,
    input  logic [W-1:0]               acc,
    input  logic                       acc_signed,
    input  logic                       saturate,
    output logic [OUT_ACC-1:0]         y,
    output logic                       sat
);

    logic [RBE_SCALE_SEL_W-1:0] s;
    logic [W-1:0]               x_ext;
    logic [W-1:0]               rnd;
    logic [W-1:0]               biased;

    always_comb begin
        s = (int'(sel) < N_SHIFTS) ? sel : '0;
        if (signed_mode) begin
            x_ext = W'($signed(x));
        end else begin
            x_ext = W'(x);
        end
        // (1<<s)>>1 is half an LSB of the result, and zero when s==0
        rnd    = round_en ? ((W'(1) << s) >> 1) : '0;
        biased = x_ext + rnd;
        if (!right_shift) begin
            shifted = x_ext << s;
        end else if (signed_mode) begin
            shifted = W'($signed(biased) >>> s);
        end else begin
            shifted = biased >> s;
        end
    end

    generate
        if (OUT_ACC >= W) begin : g_extend
            logic unused_sat;
            assign unused_sat = saturate;
            assign y   = acc_signed ? OUT_ACC'($signed(acc)) : OUT_ACC'(acc);
            assign sat = 1'b0;
        end else begin : g_clamp
            logic fits_s;
            logic fits_u;
            // Signed fits when all discarded bits equal the new sign bit
            assign fits_s = (&acc[W-1:OUT_ACC-1]) | ~(|acc[W-1:OUT_ACC-1]);
            assign fits_u = ~(|acc[W-1:OUT_ACC]);

            always_comb begin
                y   = acc[OUT_ACC-1:0];
                sat = 1'b0;
                if (saturate) begin
                    if (acc_signed && !fits_s) begin
                        sat = 1'b1;
                        y   = acc[W-1] ? {1'b1, {(OUT_ACC-1){1'b0}}}
                                       : {1'b0, {(OUT_ACC-1){1'b1}}};
                    end else if (!acc_signed && !fits_u) begin
                        sat = 1'b1;
                        y   = '1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/rbe_scale_pipe.sv
// Two-stage, N_CH-wide shift/round/saturate pipeline with valid/ready
// backpressure and a sticky per-beat saturation counter.
module rbe_scale_pipe
    import rbe_package::*;
#(
    parameter int  INP_ACC  = 8,
    parameter int  OUT_ACC  = 16,
    parameter int  N_SHIFTS = RBE_SCALE_N_SHIFTS,
    parameter int  N_CH     = 4,
    localparam int W        = INP_ACC + N_SHIFTS + 1,
    localparam int DW_IN    = N_CH * INP_ACC,
    localparam int DW_OUT   = N_CH * OUT_ACC,
    localparam int STRB_IN  = (DW_IN + 7) / 8,
    localparam int STRB_OUT = (DW_OUT + 7) / 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                test_mode_i,
    input  logic                data_i_valid,
    output logic                data_i_ready,
    input  logic [DW_IN-1:0]    data_i_data,
    input  logic [STRB_IN-1:0]  data_i_strb,
    output logic                data_o_valid,
    input  logic                data_o_ready,
    output logic [DW_OUT-1:0]   data_o_data,
    output logic [STRB_OUT-1:0] data_o_strb,
    input  ctrl_scale_pipe_t    ctrl_i,
    output flags_scale_pipe_t   flags_o
);

    logic                          s1_valid_reg;
    logic [N_CH-1:0][W-1:0]        s1_acc_reg;
    logic                          s1_signed_reg;
    logic                          s1_saturate_reg;
    logic [RBE_SCALE_SEL_W-1:0]    s1_sel_reg;

    logic                          s2_valid_reg;
    logic [DW_OUT-1:0]             s2_data_reg;
    logic                          s2_sat_reg;
    logic [RBE_SCALE_SEL_W-1:0]    s2_sel_reg;

    logic [RBE_SCALE_SATCNT_W-1:0] sat_count_reg;

    logic [N_CH-1:0][W-1:0]        ch_shifted;
    logic [DW_OUT-1:0]             ch_y;
    logic [N_CH-1:0]               ch_sat;

    logic s2_load;
    logic out_fire;
    logic unused_ok;

    assign unused_ok    = ^{test_mode_i, data_i_strb};
    assign s2_load      = !s2_valid_reg || data_o_ready;
    // s1 frees up exactly when it is empty or can move into s2 this edge
    assign data_i_ready = !s1_valid_reg || s2_load;
    assign out_fire     = s2_valid_reg && data_o_ready;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            rbe_scale_pipe_ch #(
                .INP_ACC  (INP_ACC),
                .OUT_ACC  (OUT_ACC),
                .N_SHIFTS (N_SHIFTS)
            ) u_ch (
                .x           (data_i_data[gi*INP_ACC +: INP_ACC]),
                .sel         (ctrl_i.shift_sel),
                .right_shift (ctrl_i.right_shift),
                .signed_mode (ctrl_i.signed_mode),
                .round_en    (ctrl_i.round_en),
                .shifted     (ch_shifted[gi]),
                .acc         (s1_acc_reg[gi]),
                .acc_signed  (s1_signed_reg),
                .saturate    (s1_saturate_reg),
                .y           (ch_y[gi*OUT_ACC +: OUT_ACC]),
                .sat         (ch_sat[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_reg    <= 1'b0;
            s1_acc_reg      <= '0;
            s1_signed_reg   <= 1'b0;
            s1_saturate_reg <= 1'b0;
            s1_sel_reg      <= '0;
        end else if (data_i_ready) begin
            s1_valid_reg <= data_i_valid;
            if (data_i_valid) begin
                s1_acc_reg      <= ch_shifted;
                s1_signed_reg   <= ctrl_i.signed_mode;
                s1_saturate_reg <= ctrl_i.saturate;
                s1_sel_reg      <= ctrl_i.shift_sel;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            s2_sat_reg   <= 1'b0;
            s2_sel_reg   <= '0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_data_reg <= ch_y;
                s2_sat_reg  <= |ch_sat;
                s2_sel_reg  <= s1_sel_reg;
            end
        end
    end

    // Counted once per beat on the output handshake; clear wins over increment
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sat_count_reg <= '0;
        end else if (ctrl_i.clear) begin
            sat_count_reg <= '0;
        end else if (out_fire && s2_sat_reg && (sat_count_reg != '1)) begin
            sat_count_reg <= sat_count_reg + 1'b1;
        end
    end

    assign data_o_valid = s2_valid_reg;
    assign data_o_data  = s2_data_reg;
    assign data_o_strb  = {STRB_OUT{s2_valid_reg}};

    assign flags_o = '{busy:      s1_valid_reg | s2_valid_reg,
                       sat_count: sat_count_reg,
                       shift_sel: s2_sel_reg};

endmodule

// File: tb/tb_rbe_scale_pipe.sv
// Directed bench for rbe_scale_pipe: default 16-bit instance plus a 12-bit instance for saturation.
module tb_rbe_scale_pipe;
    import rbe_package::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance (OUT_ACC = 16)
    logic              d_valid = 1'b0;
    logic              d_in_ready;
    logic [31:0]       d_data = '0;
    logic              d_out_valid;
    logic              d_ready = 1'b1;
    logic [63:0]       d_out;
    logic [7:0]        d_strb;
    ctrl_scale_pipe_t  d_ctrl = '0;
    flags_scale_pipe_t d_flags;

    // Narrow instance (OUT_ACC = 12)
    logic              n_valid = 1'b0;
    logic              n_in_ready;
    logic [31:0]       n_data = '0;
    logic              n_out_valid;
    logic [47:0]       n_out;
    logic [5:0]        n_strb;
    ctrl_scale_pipe_t  n_ctrl = '0;
    flags_scale_pipe_t n_flags;

    int n_checks = 0;
    int n_fail   = 0;

    rbe_scale_pipe u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .test_mode_i  (1'b0),
        .data_i_valid (d_valid),
        .data_i_ready (d_in_ready),
        .data_i_data  (d_data),
        .data_i_strb  (4'hF),
        .data_o_valid (d_out_valid),
        .data_o_ready (d_ready),
        .data_o_data  (d_out),
        .data_o_strb  (d_strb),
        .ctrl_i       (d_ctrl),
        .flags_o      (d_flags)
    );

    rbe_scale_pipe #(.OUT_ACC(12)) u_dut12 (
        .clk_i        (clk),
        .rst_i        (rst),
        .test_mode_i  (1'b0),
        .data_i_valid (n_valid),
        .data_i_ready (n_in_ready),
        .data_i_data  (n_data),
        .data_i_strb  (4'h0),
        .data_o_valid (n_out_valid),
        .data_o_ready (1'b1),
        .data_o_data  (n_out),
        .data_o_strb  (n_strb),
        .ctrl_i       (n_ctrl),
        .flags_o      (n_flags)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic ctrl_scale_pipe_t mk(input int sel, input bit right, input bit sgn,
                                            input bit rnd, input bit sat);
        ctrl_scale_pipe_t c;
        c             = '0;
        c.shift_sel   = RBE_SCALE_SEL_W'(sel);
        c.right_shift = right;
        c.signed_mode = sgn;
        c.round_en    = rnd;
        c.saturate    = sat;
        return c;
    endfunction

    function automatic logic [31:0] beat_in(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, b, b, b};
    endfunction

    function automatic logic [63:0] beat_out(input int i);
        logic [15:0] h;
        h = 16'(i);
        return {h, h, h, h};
    endfunction

    int in_idx;
    int out_idx;

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_out_valid", 64'(d_out_valid), 64'd0);
        check("rst_out_data", d_out, 64'd0);
        check("rst_in_ready", 64'(d_in_ready), 64'd1);
        check("rst_sat_count", 64'(d_flags.sat_count), 64'd0);
        check("rst_busy", 64'(d_flags.busy), 64'd0);
        check("rst_shift_sel", 64'(d_flags.shift_sel), 64'd0);
        rst = 1'b0;
        step();

        // Signed left shift 3 of -112 -> -896
        d_ctrl  = mk(3, 0, 1, 0, 1);
        d_data  = 32'h90909090;
        d_valid = 1'b1;
        step();
        d_valid = 1'b0;
        check("lat1_not_valid", 64'(d_out_valid), 64'd0);
        step();
        check("sl3_valid", 64'(d_out_valid), 64'd1);
        check("sl3_data", d_out, 64'hFC80FC80FC80FC80);
        check("sl3_strb", 64'(d_strb), 64'hFF);
        check("sl3_sat_count", 64'(d_flags.sat_count), 64'd0);
        step();

        // Unsigned right shift 2, rounded then truncating
        d_ctrl  = mk(2, 1, 0, 1, 0);
        d_data  = 32'h07060504;
        d_valid = 1'b1;
        step();
        d_ctrl  = mk(2, 1, 0, 0, 0);
        d_data  = 32'h07070707;
        step();
        d_ctrl  = mk(1, 1, 1, 1, 0);
        d_data  = 32'hFBFB0380;
        check("ur2_round", d_out, 64'h0002000200010001);
        step();
        d_valid = 1'b0;
        check("ur2_trunc", d_out, 64'h0001000100010001);
        step();
        check("sr1_round", d_out, 64'hFFFEFFFE0002FFC0);
        step();

        // 12-bit instance: signed clamp, wrap, unsigned clamp, clear
        n_ctrl  = mk(7, 0, 1, 0, 1);
        n_data  = 32'h7F7F8001;
        n_valid = 1'b1;
        step();
        n_valid = 1'b0;
        step();
        check("n_sat_s_data", 64'(n_out), 64'h7FF7FF800080);
        check("n_sat_s_strb", 64'(n_strb), 64'h3F);
        check("n_sat_s_sel", 64'(n_flags.shift_sel), 64'd7);
        step();
        check("n_sat_cnt1", 64'(n_flags.sat_count), 64'd1);
        n_ctrl  = mk(7, 0, 1, 0, 0);
        n_valid = 1'b1;
        step();
        n_valid = 1'b0;
        step();
        check("n_wrap_data", 64'(n_out), 64'hF80F80000080);
        step();
        check("n_wrap_cnt", 64'(n_flags.sat_count), 64'd1);
        n_ctrl  = mk(5, 0, 0, 0, 1);
        n_data  = 32'hFF7F1001;
        n_valid = 1'b1;
        step();
        n_valid = 1'b0;
        step();
        check("n_sat_u_data", 64'(n_out), 64'hFFFFE0200020);
        step();
        check("n_sat_cnt2", 64'(n_flags.sat_count), 64'd2);
        n_ctrl.clear = 1'b1;
        step();
        n_ctrl.clear = 1'b0;
        check("n_clear", 64'(n_flags.sat_count), 64'd0);

        // Backpressure: 10 beats, downstream stalled first
        d_ready = 1'b0;
        d_ctrl  = mk(0, 0, 0, 0, 0);
        in_idx  = 0;
        d_valid = 1'b1;
        d_data  = beat_in(1);
        check("stall_rdy_a", 64'(d_in_ready), 64'd1);
        step();
        in_idx  = 1;
        d_data  = beat_in(2);
        check("stall_rdy_b", 64'(d_in_ready), 64'd1);
        step();
        in_idx  = 2;
        d_data  = beat_in(3);
        check("stall_rdy_low", 64'(d_in_ready), 64'd0);
        for (int c = 0; c < 5; c++) begin
            check("stall_hold", d_out, beat_out(1));
            check("stall_hold_rdy", 64'(d_in_ready), 64'd0);
            step();
        end
        d_ready = 1'b1;
        #1;
        out_idx = 0;
        for (int c = 0; c < 40 && out_idx < 10; c++) begin
            check("stream_valid", 64'(d_out_valid), 64'd1);
            check("stream_data", d_out, beat_out(out_idx + 1));
            out_idx++;
            if (d_valid && d_in_ready) in_idx++;
            step();
            if (in_idx >= 10) d_valid = 1'b0;
            else              d_data  = beat_in(in_idx + 1);
        end
        check("stream_count", 64'(out_idx), 64'd10);
        check("stream_drained", 64'(d_flags.busy), 64'd0);

        // Control changes between back-to-back beats
        d_ctrl  = mk(1, 0, 0, 0, 0);
        d_data  = 32'h03030303;
        d_valid = 1'b1;
        step();
        d_ctrl  = mk(4, 0, 0, 0, 0);
        step();
        d_valid = 1'b0;
        check("sel1_data", d_out, 64'h0006000600060006);
        check("sel1_flag", 64'(d_flags.shift_sel), 64'd1);
        step();
        check("sel4_data", d_out, 64'h0030003000300030);
        check("sel4_flag", 64'(d_flags.shift_sel), 64'd4);
        step();

        // Asynchronous reset with two beats in flight
        d_ctrl  = mk(0, 0, 0, 0, 0);
        d_data  = 32'h11111111;
        d_valid = 1'b1;
        step();
        d_data  = 32'h22222222;
        step();
        d_valid = 1'b0;
        check("pre_rst_busy", 64'(d_flags.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(d_out_valid), 64'd0);
        check("arst_busy", 64'(d_flags.busy), 64'd0);
        check("arst_data", d_out, 64'd0);
        check("arst_in_ready", 64'(d_in_ready), 64'd1);
        step();
        rst     = 1'b0;
        d_ctrl  = mk(2, 0, 0, 0, 0);
        d_data  = 32'h33333333;
        d_valid = 1'b1;
        step();
        d_valid = 1'b0;
        check("post_rst_lat1", 64'(d_out_valid), 64'd0);
        step();
        check("post_rst_valid", 64'(d_out_valid), 64'd1);
        check("post_rst_data", d_out, 64'h00CC00CC00CC00CC);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
